fifo_rd_stream: RTL and testbench
=================================

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 The block SHALL have parameter DW, default 8, data width in bits, equal to the upstream FIFO data width.
REQ-002 The block SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port fifo_rd_en  output  1  read strobe to the upstream synchronous FIFO.
REQ-005 The block SHALL have port fifo_dout  input  DW  FIFO read data, valid exactly one cycle after fifo_rd_en.
REQ-006 The block SHALL have port fifo_empty  input  1  FIFO empty flag, registered in the FIFO.
REQ-007 The block SHALL have port flush  input  1  synchronous discard of all buffered and in-flight data.
REQ-008 The block SHALL have port m_valid  output  1  output stream data valid.
REQ-009 The block SHALL have port m_ready  input  1  output stream sink ready.
REQ-010 The block SHALL have port m_data  output  DW  output stream data.
REQ-011 The block SHALL have port m_count  output  2  entries held in the local buffer, 0..2.

Function
REQ-012 The block SHALL hold a 2-entry in-order local buffer (head = m_data) plus a 1-bit in-flight flag inflight, set in the cycle after fifo_rd_en=1 and otherwise clear.
REQ-013 The block SHALL define pop = m_valid && m_ready, and m_valid SHALL equal (m_count != 0).
REQ-014 The block SHALL drive fifo_rd_en = !fifo_empty && !flush && !rst && (m_count + inflight - pop < 2), combinationally.
REQ-015 The block SHALL capture fifo_dout into the buffer tail only in cycles where inflight=1 and flush=0; fifo_dout is ignored otherwise.
REQ-016 The block SHALL sustain one beat per cycle when the FIFO is non-empty and m_ready=1 continuously, after 2 cycles of initial latency (rd_en cycle, capture cycle; m_valid first high in the cycle after capture).
REQ-017 The block SHALL hold m_data and m_valid stable while m_valid=1 and m_ready=0.
REQ-018 A simultaneous capture and pop SHALL leave m_count unchanged and advance the head in order.
REQ-019 A capture SHALL never occur with m_count=2 and pop=0; REQ-014 guarantees this, and an assertion SHALL check it.
REQ-020 flush=1 SHALL set m_count to 0 and inflight to 0 next cycle, discard the data returning that cycle, and force fifo_rd_en=0 in the flush cycle.
REQ-021 m_count SHALL be 2 bits unsigned, and the sum m_count+inflight SHALL be evaluated 3 bits wide to avoid wrap.

Reset
REQ-022 While rst=1, fifo_rd_en SHALL be 0; next edge m_count=0, m_valid=0, inflight=0, and m_data is don't-care.
REQ-023 Reset asserted mid-transfer SHALL discard buffered and in-flight data exactly as flush.
REQ-024 The block SHALL tolerate fifo_empty reading 1 or 0 during and just after reset and SHALL issue no read before the first cycle with rst=0.

Structure
REQ-025 The shared package SHALL hold the constant RD_STREAM_BUF_DEPTH = 2 and the 3-bit occupancy-sum width; no typedefs are required.
REQ-026 The local buffer SHALL be one sub-module, reg_fifo2: a 2-entry register FIFO with push, pop, data, count and a flush input.
REQ-027 The top level SHALL contain only the rd_en issue logic and the inflight register.

Verification
REQ-028 The bench SHALL model the upstream FIFO with 1-cycle read latency and a registered empty flag, and SHALL scoreboard the output order.
REQ-029 Streaming: preload 8 words 0x01..0x08, m_ready=1 -> rd_en cycles 0..7, m_valid cycles 2..9, data 0x01..0x08 in order, no bubbles.
REQ-030 Backpressure: 4 words queued, m_ready=0 -> exactly 2 rd_en pulses, m_count=2, m_data=first word stable; m_ready=1 -> remaining words delivered in order, no loss or duplication.
REQ-031 Alternating m_ready 1/0 over 16 words -> 16 beats in order, m_count never >2, REQ-019 assertion never fires.
REQ-032 Single word: FIFO holds 0xA5 then goes empty -> one rd_en, m_valid 1 cycle after capture, m_count returns to 0, no further rd_en.
REQ-033 flush asserted in a cycle with inflight=1 and m_count=1 -> next cycle m_count=0, m_valid=0, returned word dropped; the next FIFO word is the first output.
REQ-034 rst pulsed for 1 cycle mid-stream with m_count=2 -> outputs per REQ-022 and the stream resumes from the FIFO's post-reset state.

Source files
------------

// File: rtl/fifo_rd_stream_pkg.sv
// Shared constants for the FIFO read-to-stream adapter.
package fifo_rd_stream_pkg;
    localparam int RD_STREAM_BUF_DEPTH = 2;
    localparam int RD_STREAM_SUM_W     = 3;
endpackage

// File: rtl/reg_fifo2.sv
// Two-entry register FIFO; head entry is presented on data, count is 0..2.
module reg_fifo2
    import fifo_rd_stream_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] data,
    output logic [1:0]    count
);

    logic [DW-1:0] tail;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; count alone decides what is meaningful.
    always_ff @(posedge clk) begin
        if (pop) begin
            data <= (push && count == 2'd1) ? push_data : tail;
            if (push)
                tail <= push_data;
        end else if (push) begin
            if (count == 2'd0)
                data <= push_data;
            else
                tail <= push_data;
        end
    end

endmodule

// File: rtl/fifo_rd_stream.sv
// Turns a 1-cycle-latency synchronous FIFO read port into a valid/ready stream
// at full rate, using a 2-entry skid buffer sized for the read latency.
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    output logic          fifo_rd_en,
    input  logic [DW-1:0] fifo_dout,
    input  logic          fifo_empty,
    input  logic          flush,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic [1:0]    m_count
);

    logic                       inflight;
    logic                       pop;
    logic                       capture;
    logic [RD_STREAM_SUM_W-1:0] occ;

    assign m_valid = (m_count != 2'd0);
    assign pop     = m_valid && m_ready;
    assign capture = inflight && !flush && !rst;

    // Occupancy after this cycle's pop; 3 bits so count+inflight cannot wrap.
    assign occ = RD_STREAM_SUM_W'(m_count) + RD_STREAM_SUM_W'(inflight)
               - RD_STREAM_SUM_W'(pop);

    assign fifo_rd_en = !fifo_empty && !flush && !rst
                      && (occ < RD_STREAM_SUM_W'(RD_STREAM_BUF_DEPTH));

    always_ff @(posedge clk) begin
        if (rst)
            inflight <= 1'b0;
        else
            inflight <= fifo_rd_en;
    end

    reg_fifo2 #(.DW(DW)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (capture),
        .push_data (fifo_dout),
        .pop       (pop),
        .data      (m_data),
        .count     (m_count)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(capture && m_count == 2'd2 && !pop));

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench: upstream FIFO model with registered empty, output beat log.
module tb_fifo_rd_stream;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fifo_rd_en;
    logic [7:0] fifo_dout = 8'h00;
    logic       fifo_empty = 1'b1;
    logic       flush = 1'b0;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;
    logic [1:0] m_count;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int max_cnt = 0;

    logic [7:0] mem [0:255];
    logic [7:0] wr_ptr = 8'd0;
    logic [7:0] rd_ptr = 8'd0;

    logic [7:0] got[$];
    int         got_cyc[$];
    int         rd_cyc[$];

    fifo_rd_stream #(.DW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .flush      (flush),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_count    (m_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Upstream FIFO: data one cycle after rd_en, empty flag registered.
    always @(posedge clk) begin
        if (fifo_rd_en && !fifo_empty) begin
            fifo_dout <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 8'd1;
        end
        fifo_empty <= (wr_ptr == (rd_ptr + ((fifo_rd_en && !fifo_empty) ? 8'd1 : 8'd0)));
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (fifo_rd_en) rd_cyc.push_back(cyc);
            if (m_valid && m_ready) begin
                got.push_back(m_data);
                got_cyc.push_back(cyc);
            end
            if (int'(m_count) > max_cnt) max_cnt = int'(m_count);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] v);
        mem[wr_ptr] = v;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic test_reset();
        int gb, rb;
        rst = 1'b1; m_ready = 1'b0; flush = 1'b0;
        repeat (3) tick();
        push(8'h11);
        repeat (2) tick();
        @(negedge clk);
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL rst_rd_en: got %0b want 0", fifo_rd_en); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b want 0", m_valid); end
        checks++; if (m_count !== 2'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", m_count); end
        gb = got.size(); rb = rd_cyc.size();
        tick();
        rst = 1'b0; m_ready = 1'b1;
        @(negedge clk);
        checks++; if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL first_rd_en: got %0b want 1", fifo_rd_en); end
        repeat (5) tick();
        @(negedge clk);
        checks++; if (rd_cyc.size() - rb != 1) begin errors++; $display("FAIL post_rst_reads: got %0d want 1", rd_cyc.size() - rb); end
        checks++;
        if (got.size() - gb != 1) begin errors++; $display("FAIL post_rst_beats: got %0d want 1", got.size() - gb); end
        else if (got[gb] !== 8'h11) begin errors++; $display("FAIL post_rst_data: got %0h want 11", got[gb]); end
        checks++; if (m_count !== 2'd0) begin errors++; $display("FAIL post_rst_count: got %0d want 0", m_count); end
    endtask

    task automatic test_stream();
        int gb, rb;
        gb = got.size(); rb = rd_cyc.size();
        m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) push(8'(i));
        repeat (14) tick();
        @(negedge clk);
        checks++;
        if (rd_cyc.size() - rb != 8) begin errors++; $display("FAIL stream_reads: got %0d want 8", rd_cyc.size() - rb); end
        else for (int i = 1; i < 8; i++) begin
            checks++;
            if (rd_cyc[rb+i] != rd_cyc[rb] + i) begin errors++; $display("FAIL stream_rd_cyc%0d: got %0d want %0d", i, rd_cyc[rb+i], rd_cyc[rb] + i); end
        end
        checks++;
        if (got.size() - gb != 8 || rd_cyc.size() - rb < 1) begin errors++; $display("FAIL stream_beats: got %0d want 8", got.size() - gb); end
        else for (int i = 0; i < 8; i++) begin
            checks++;
            if (got[gb+i] !== 8'(i + 1)) begin errors++; $display("FAIL stream_data%0d: got %0h want %0h", i, got[gb+i], i + 1); end
            checks++;
            if (got_cyc[gb+i] != rd_cyc[rb] + 2 + i) begin errors++; $display("FAIL stream_beat_cyc%0d: got %0d want %0d", i, got_cyc[gb+i], rd_cyc[rb] + 2 + i); end
        end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL stream_idle_valid: got %0b want 0", m_valid); end
    endtask

    task automatic test_backpressure();
        int gb, rb;
        gb = got.size(); rb = rd_cyc.size();
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(8'h21 + 8'(i));
        repeat (8) tick();
        @(negedge clk);
        checks++; if (rd_cyc.size() - rb != 2) begin errors++; $display("FAIL bp_reads: got %0d want 2", rd_cyc.size() - rb); end
        checks++; if (m_count !== 2'd2) begin errors++; $display("FAIL bp_count: got %0d want 2", m_count); end
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %0b want 1", m_valid); end
        checks++; if (m_data !== 8'h21) begin errors++; $display("FAIL bp_data: got %0h want 21", m_data); end
        repeat (3) tick();
        @(negedge clk);
        checks++; if (m_data !== 8'h21) begin errors++; $display("FAIL bp_data_hold: got %0h want 21", m_data); end
        checks++; if (rd_cyc.size() - rb != 2) begin errors++; $display("FAIL bp_reads_hold: got %0d want 2", rd_cyc.size() - rb); end
        tick();
        m_ready = 1'b1;
        repeat (8) tick();
        @(negedge clk);
        checks++;
        if (got.size() - gb != 4) begin errors++; $display("FAIL bp_beats: got %0d want 4", got.size() - gb); end
        else for (int i = 0; i < 4; i++) begin
            checks++;
            if (got[gb+i] !== 8'h21 + 8'(i)) begin errors++; $display("FAIL bp_out%0d: got %0h want %0h", i, got[gb+i], 8'h21 + 8'(i)); end
        end
        checks++; if (m_count !== 2'd0) begin errors++; $display("FAIL bp_drain_count: got %0d want 0", m_count); end
    endtask

    task automatic test_alternate();
        int gb;
        gb = got.size();
        for (int i = 0; i < 16; i++) push(8'h30 + 8'(i));
        for (int i = 0; i < 60; i++) begin
            tick();
            m_ready = (i % 2 == 0);
        end
        tick();
        m_ready = 1'b1;
        repeat (5) tick();
        @(negedge clk);
        checks++;
        if (got.size() - gb != 16) begin errors++; $display("FAIL alt_beats: got %0d want 16", got.size() - gb); end
        else for (int i = 0; i < 16; i++) begin
            checks++;
            if (got[gb+i] !== 8'h30 + 8'(i)) begin errors++; $display("FAIL alt_out%0d: got %0h want %0h", i, got[gb+i], 8'h30 + 8'(i)); end
        end
        checks++; if (max_cnt > 2) begin errors++; $display("FAIL alt_max_count: got %0d want <=2", max_cnt); end
    endtask

    task automatic test_single();
        int gb, rb;
        gb = got.size(); rb = rd_cyc.size();
        m_ready = 1'b1;
        push(8'hA5);
        repeat (8) tick();
        @(negedge clk);
        checks++; if (rd_cyc.size() - rb != 1) begin errors++; $display("FAIL single_reads: got %0d want 1", rd_cyc.size() - rb); end
        checks++;
        if (got.size() - gb != 1 || rd_cyc.size() - rb < 1) begin errors++; $display("FAIL single_beats: got %0d want 1", got.size() - gb); end
        else begin
            if (got[gb] !== 8'hA5) begin errors++; $display("FAIL single_data: got %0h want a5", got[gb]); end
            checks++;
            if (got_cyc[gb] != rd_cyc[rb] + 2) begin errors++; $display("FAIL single_latency: got %0d want %0d", got_cyc[gb], rd_cyc[rb] + 2); end
        end
        checks++; if (m_count !== 2'd0) begin errors++; $display("FAIL single_count: got %0d want 0", m_count); end
    endtask

    task automatic test_flush();
        int gb, rb;
        bit found;
        gb = got.size(); rb = rd_cyc.size();
        m_ready = 1'b0;
        found = 1'b0;
        push(8'h41); push(8'h42); push(8'h43);
        for (int i = 0; i < 10; i++) begin
            tick();
            @(negedge clk);
            if (m_count == 2'd1) begin found = 1'b1; break; end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL flush_setup: got count %0d want 1", m_count); end
        else begin
            checks++;
            if (rd_cyc.size() - rb != 2 || rd_cyc[rd_cyc.size()-1] != cyc - 1) begin
                errors++; $display("FAIL flush_inflight: got reads %0d want 2 with last in previous cycle", rd_cyc.size() - rb);
            end
            flush = 1'b1;
            #1;
            checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL flush_rd_en: got %0b want 0", fifo_rd_en); end
            tick();
            flush = 1'b0;
            @(negedge clk);
            checks++; if (m_count !== 2'd0) begin errors++; $display("FAIL flush_count: got %0d want 0", m_count); end
            checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %0b want 0", m_valid); end
            tick();
            m_ready = 1'b1;
            repeat (6) tick();
            @(negedge clk);
            checks++;
            if (got.size() - gb != 1) begin errors++; $display("FAIL flush_beats: got %0d want 1", got.size() - gb); end
            else if (got[gb] !== 8'h43) begin errors++; $display("FAIL flush_first: got %0h want 43", got[gb]); end
        end
    endtask

    task automatic test_reset_mid();
        int gb;
        bit found;
        gb = got.size();
        m_ready = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 5; i++) push(8'h51 + 8'(i));
        for (int i = 0; i < 10; i++) begin
            tick();
            @(negedge clk);
            if (m_count == 2'd2) begin found = 1'b1; break; end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL rstmid_setup: got count %0d want 2", m_count); end
        else begin
            tick();
            rst = 1'b1;
            @(negedge clk);
            checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL rstmid_rd_en: got %0b want 0", fifo_rd_en); end
            tick();
            rst = 1'b0;
            @(negedge clk);
            checks++; if (m_count !== 2'd0) begin errors++; $display("FAIL rstmid_count: got %0d want 0", m_count); end
            checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %0b want 0", m_valid); end
            tick();
            m_ready = 1'b1;
            repeat (10) tick();
            @(negedge clk);
            checks++;
            if (got.size() - gb != 3) begin errors++; $display("FAIL rstmid_beats: got %0d want 3", got.size() - gb); end
            else for (int i = 0; i < 3; i++) begin
                checks++;
                if (got[gb+i] !== 8'h53 + 8'(i)) begin errors++; $display("FAIL rstmid_out%0d: got %0h want %0h", i, got[gb+i], 8'h53 + 8'(i)); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_alternate();
        test_single();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
